// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART definitions: state encodings, default bit timing and frame length.
// Kept in one package so the planned uart_tx block uses the same constants.
package uart_rx_frontend_pkg;

  typedef enum logic [1:0] {
    UART_ST_IDLE  = 2'd0,
    UART_ST_START = 2'd1,
    UART_ST_DATA  = 2'd2,
    UART_ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
  localparam int UART_FRAME_BITS           = 10;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_frontend_sync.sv
// Multi-flop synchronizer for asynchronous ui_in lines, with a selectable
// reset value so idle-high lines do not see a spurious edge out of reset.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: synchronizer, bit-timing FSM and a one-entry output
// buffer with framing-error and overrun pulses.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(UART_DATA_BITS - 1);

  uart_state_e   state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          rx_s;
  logic          rx_prev;
  logic          byte_done;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign state_dbg = state;

  // rx_prev tracks rx_s in every state, so a line held low after a frame
  // cannot look like a new falling edge when the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UART_ST_IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_prev     <= 1'b1;
      byte_done   <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      byte_done   <= 1'b0;
      frame_err_o <= 1'b0;
      if (!ena) begin
        state   <= UART_ST_IDLE;
        cyc_cnt <= '0;
        bit_cnt <= '0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          UART_ST_IDLE: begin
            if (rx_prev && !rx_s) begin
              state   <= UART_ST_START;
              cyc_cnt <= '0;
              busy_o  <= 1'b1;
            end
          end
          UART_ST_START: begin
            if (cyc_cnt == HALF_LAST) begin
              cyc_cnt <= '0;
              if (!rx_s) begin
                state   <= UART_ST_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= UART_ST_IDLE;
                busy_o <= 1'b0;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          UART_ST_DATA: begin
            if (cyc_cnt == BIT_LAST) begin
              cyc_cnt        <= '0;
              shift[bit_cnt] <= rx_s;
              if (bit_cnt == LAST_DATA) begin
                state   <= UART_ST_STOP;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          UART_ST_STOP: begin
            if (cyc_cnt == BIT_LAST) begin
              cyc_cnt <= '0;
              state   <= UART_ST_IDLE;
              busy_o  <= 1'b0;
              if (rx_s) begin
                byte_done <= 1'b1;
              end else begin
                frame_err_o <= 1'b1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          default: begin
            state   <= UART_ST_IDLE;
            cyc_cnt <= '0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Handshake: a byte transfers on any cycle with valid_o & ready_i. valid_o
  // never drops without ready_i, and data_o changes only when a byte loads,
  // which may coincide with a transfer (load-while-consume).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (byte_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: drives 8N1 frames, scoreboards presented bytes
// and checks latency, error pulses, ena/rst aborts and buffer behaviour.
module tb_uart_rx_frontend;

  localparam int N       = 16;
  localparam int SYNC    = 2;
  localparam int H       = N / 2;
  localparam int LATENCY = SYNC + H + 9 * N + 1;
  localparam int FULL    = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int  start_edge = 0;
  bit  lat_en     = 1'b0;
  int  n_events   = 0;
  int  ferr_cycles = 0, ferr_pulses = 0;
  int  ovr_cycles  = 0, ovr_pulses  = 0;
  int  starts      = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_busy = 1'b0;

  int s_ferr_c, s_ferr_p, s_ovr_c, s_ovr_p, s_starts, s_events;

  uart_rx_frontend #(
    .CLKS_PER_BIT (N),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the falling edge, so they are stable
  // for the next rising edge and the negedge monitor sees what that edge saw.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drives start, 8 data bits LSB first, then stop_bit; stops early after
  // max_ticks. Leaves rx_i at the last driven level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int max_ticks);
    logic [9:0] fr;
    int t;
    fr = {stop_bit, b, 1'b0};
    t  = 0;
    start_edge = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < N; k++) begin
        if (t < max_ticks) begin
          rx_i = fr[i];
          tick();
          t++;
        end
      end
    end
  endtask

  task automatic snap();
    s_ferr_c = ferr_cycles; s_ferr_p = ferr_pulses;
    s_ovr_c  = ovr_cycles;  s_ovr_p  = ovr_pulses;
    s_starts = starts;      s_events = n_events;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && (!prev_valid || ready_i)) begin
        n_events++;
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("data_o", 32'(data_o), 32'(exp_b));
        end
        if (lat_en) begin
          lat_en = 1'b0;
          check("latency", 32'(cyc - start_edge), 32'(LATENCY));
          check("busy_at_valid", 32'(busy_o), 32'd0);
        end
      end
      if (frame_err_o) ferr_cycles++;
      if (frame_err_o && !prev_ferr) ferr_pulses++;
      if (overrun_o) ovr_cycles++;
      if (overrun_o && !prev_ovr) ovr_pulses++;
      if (busy_o && !prev_busy) starts++;
    end
    prev_valid = valid_o;
    prev_ferr  = frame_err_o;
    prev_ovr   = overrun_o;
    prev_busy  = busy_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ena = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    idle(3);
    rst = 1'b0;
    tick();
    check("rst_data",  32'(data_o),      32'h00);
    check("rst_valid", 32'(valid_o),     32'd0);
    check("rst_ferr",  32'(frame_err_o), 32'd0);
    check("rst_ovr",   32'(overrun_o),   32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_state", 32'(state_dbg),   32'd0);
    idle(5);

    // A5, not consumed: latency and hold
    exp_q.push_back(8'hA5);
    lat_en = 1'b1;
    send_frame(8'hA5, 1'b1, FULL);
    idle(10);
    check("a5_valid_held", 32'(valid_o), 32'd1);
    check("a5_data_held",  32'(data_o),  32'hA5);
    check("a5_lat_seen",   32'(lat_en),  32'd0);
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    check("a5_consumed", 32'(valid_o), 32'd0);
    check("a5_data_kept", 32'(data_o), 32'hA5);

    // back-to-back 00, FF with ready held
    snap();
    ready_i = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, FULL);
    send_frame(8'hFF, 1'b1, FULL);
    idle(30);
    ready_i = 1'b0;
    check("b2b_events", 32'(n_events - s_events), 32'd2);
    check("b2b_ferr",   32'(ferr_cycles - s_ferr_c), 32'd0);
    check("b2b_ovr",    32'(ovr_cycles - s_ovr_c), 32'd0);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // framing error, then line held low
    snap();
    send_frame(8'h3C, 1'b0, FULL);
    idle(40);
    check("fe_pulses", 32'(ferr_pulses - s_ferr_p), 32'd1);
    check("fe_width",  32'(ferr_cycles - s_ferr_c), 32'd1);
    check("fe_valid",  32'(valid_o), 32'd0);
    check("fe_starts", 32'(starts - s_starts), 32'd1);
    check("fe_no_retrigger_busy", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    idle(20);
    ready_i = 1'b1;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, FULL);
    idle(30);
    ready_i = 1'b0;
    check("fe_11_events", 32'(n_events - s_events), 32'd1);
    check("fe_11_q_empty", 32'(exp_q.size()), 32'd0);

    // overrun, then load-while-consume
    snap();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, FULL);
    idle(10);
    send_frame(8'h34, 1'b1, FULL);
    idle(20);
    check("ovr_pulses", 32'(ovr_pulses - s_ovr_p), 32'd1);
    check("ovr_width",  32'(ovr_cycles - s_ovr_c), 32'd1);
    check("ovr_data",   32'(data_o), 32'h12);
    check("ovr_valid",  32'(valid_o), 32'd1);
    snap();
    exp_q.push_back(8'h34);
    fork
      send_frame(8'h34, 1'b1, FULL);
      begin
        idle(LATENCY);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
      end
    join
    idle(20);
    check("lwc_data",  32'(data_o), 32'h34);
    check("lwc_valid", 32'(valid_o), 32'd1);
    check("lwc_ovr",   32'(ovr_cycles - s_ovr_c), 32'd0);
    check("lwc_events", 32'(n_events - s_events), 32'd1);
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    check("lwc_consumed", 32'(valid_o), 32'd0);

    // short glitch
    snap();
    rx_i = 1'b0;
    idle(5);
    rx_i = 1'b1;
    idle(40);
    check("gl_starts", 32'(starts - s_starts), 32'd1);
    check("gl_busy",   32'(busy_o), 32'd0);
    check("gl_events", 32'(n_events - s_events), 32'd0);
    check("gl_ferr",   32'(ferr_cycles - s_ferr_c), 32'd0);

    // ena drop mid-frame with a buffered byte
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, FULL);
    idle(10);
    snap();
    send_frame(8'hC3, 1'b1, 5 * N + 4);
    rx_i = 1'b1;
    ena  = 1'b0;
    tick();
    check("ena_state", 32'(state_dbg), 32'd0);
    check("ena_busy",  32'(busy_o), 32'd0);
    check("ena_valid", 32'(valid_o), 32'd1);
    check("ena_data",  32'(data_o), 32'h77);
    idle(3);
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    check("ena_handshake", 32'(valid_o), 32'd0);
    ena = 1'b1;
    idle(10);
    ready_i = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, FULL);
    idle(30);
    ready_i = 1'b0;
    check("ena_ferr", 32'(ferr_cycles - s_ferr_c), 32'd0);
    check("ena_events", 32'(n_events - s_events), 32'd1);

    // rst mid-frame with a buffered byte
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, FULL);
    idle(10);
    snap();
    send_frame(8'hC3, 1'b1, 5 * N + 4);
    rx_i = 1'b1;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    check("rst_mid_busy",  32'(busy_o), 32'd0);
    check("rst_mid_valid", 32'(valid_o), 32'd0);
    check("rst_mid_data",  32'(data_o), 32'h00);
    idle(10);
    ready_i = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, FULL);
    idle(30);
    ready_i = 1'b0;
    check("rst_5a_events", 32'(n_events - s_events), 32'd1);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
